// File: rtl/legv8_ctrl_pkg.sv
// Shared types for the LEGv8 multi-cycle controller: state and instruction-class
// encodings, opcode match patterns, alu_op codes and the per-state control decode.
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_R, CL_I, CL_LD, CL_ST, CL_CBZ, CL_CBNZ, CL_B, CL_ILL
    } iclass_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASS  = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    // Opcode patterns as value/mask pairs; a cleared mask bit is a don't-care.
    localparam logic [10:0] OPV_LDUR = 11'b11111000010, OPM_LDUR = 11'b11111111111;
    localparam logic [10:0] OPV_STUR = 11'b11111000000, OPM_STUR = 11'b11111111111;
    localparam logic [10:0] OPV_CBZ  = 11'b10110100000, OPM_CBZ  = 11'b11111111000;
    localparam logic [10:0] OPV_CBNZ = 11'b10110101000, OPM_CBNZ = 11'b11111111000;
    localparam logic [10:0] OPV_B    = 11'b00010100000, OPM_B    = 11'b11111100000;
    localparam logic [10:0] OPV_R    = 11'b10001010000, OPM_R    = 11'b10011110111;
    localparam logic [10:0] OPV_I    = 11'b10010001000, OPM_I    = 11'b10111111100;

    typedef struct packed {
        logic       fetch;
        logic       pc_src;
        logic       reg2loc;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       pcw_uncond;
        logic       pcw_zero;
        logic       pcw_nzero;
    } ctl_t;

    function automatic logic op_match(logic [10:0] op, logic [10:0] val, logic [10:0] mask);
        return (op & mask) == val;
    endfunction

    // Moore portion of the control word; mem_ready/zero gating is applied at the top.
    function automatic ctl_t ctl_decode(state_t s, iclass_t c);
        ctl_t k;
        k = '0;
        case (s)
            ST_FETCH: begin
                k.fetch    = 1'b1;
                k.mem_read = 1'b1;
                k.alu_src  = 1'b1;
                k.alu_op   = ALU_ADD;
            end
            ST_EXEC: begin
                case (c)
                    CL_R:  k.alu_op = ALU_RTYPE;
                    CL_I:  begin k.alu_src = 1'b1; k.alu_op = ALU_ITYPE; end
                    CL_LD, CL_ST: begin k.alu_src = 1'b1; k.alu_op = ALU_ADD; end
                    CL_CBZ:  begin k.alu_op = ALU_PASS; k.reg2loc = 1'b1; k.pc_src = 1'b1; k.pcw_zero = 1'b1; end
                    CL_CBNZ: begin k.alu_op = ALU_PASS; k.reg2loc = 1'b1; k.pc_src = 1'b1; k.pcw_nzero = 1'b1; end
                    CL_B:  begin k.pc_src = 1'b1; k.pcw_uncond = 1'b1; end
                    default: ;
                endcase
            end
            ST_MEM: begin
                k.mem_read  = (c == CL_LD);
                k.mem_write = (c == CL_ST);
            end
            ST_WB: begin
                k.reg_write  = 1'b1;
                k.mem_to_reg = (c == CL_LD);
            end
            default: ;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/legv8_opcode_classify.sv
// Combinational LEGv8 opcode classifier; first matching pattern wins.
module legv8_opcode_classify
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output iclass_t     iclass
);

    always_comb begin
        iclass = CL_ILL;
        if      (op_match(opcode, OPV_LDUR, OPM_LDUR)) iclass = CL_LD;
        else if (op_match(opcode, OPV_STUR, OPM_STUR)) iclass = CL_ST;
        else if (op_match(opcode, OPV_CBZ,  OPM_CBZ))  iclass = CL_CBZ;
        else if (op_match(opcode, OPV_CBNZ, OPM_CBNZ)) iclass = CL_CBNZ;
        else if (op_match(opcode, OPV_B,    OPM_B))    iclass = CL_B;
        else if (op_match(opcode, OPV_R,    OPM_R))    iclass = CL_R;
        else if (op_match(opcode, OPV_I,    OPM_I))    iclass = CL_I;
    end

endmodule

// File: rtl/legv8_multicycle_control.sv
// LEGv8 multi-cycle control FSM (fetch/decode/exec/mem/wb) with memory-ready stalls.
// Optional perf counters (retired, stall_cycles) are built when LEGV8_CTRL_PERF_EN is defined.
module legv8_multicycle_control
    import legv8_ctrl_pkg::*;
#(
    parameter int OPC_W    = 11,
    parameter int ALUOP_W  = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_src,
    output logic               reg2loc,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic               mem_timeout,
    output logic [2:0]         state_o
`ifdef LEGV8_CTRL_PERF_EN
    ,
    output logic [31:0]        retired,
    output logic [31:0]        stall_cycles
`endif
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t            state, state_nxt;
    iclass_t           cls, cls_nxt, dec_cls;
    ctl_t              ctl;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              in_decode;

    legv8_opcode_classify u_classify (
        .opcode (11'(opcode)),
        .iclass (dec_cls)
    );

    assign in_decode = (state == ST_DECODE);
    assign waiting   = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;

    always_comb begin
        state_nxt = state;
        cls_nxt   = cls;
        case (state)
            ST_FETCH:  if (mem_ready) state_nxt = ST_DECODE;
            ST_DECODE: begin
                cls_nxt   = dec_cls;
                state_nxt = (dec_cls == CL_ILL) ? ST_FETCH : ST_EXEC;
            end
            ST_EXEC: begin
                case (cls)
                    CL_R, CL_I:   state_nxt = ST_WB;
                    CL_LD, CL_ST: state_nxt = ST_MEM;
                    default:      state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM:  if (mem_ready) state_nxt = (cls == CL_LD) ? ST_WB : ST_FETCH;
            ST_WB:   state_nxt = ST_FETCH;
            default: state_nxt = ST_FETCH;
        endcase
    end

    // The control word is registered for the state being entered, so it is valid
    // from the first cycle of that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            cls         <= CL_ILL;
            ctl         <= ctl_decode(ST_FETCH, CL_ILL);
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            cls   <= cls_nxt;
            ctl   <= ctl_decode(state_nxt, cls_nxt);
            if (mem_ready) begin
                wait_cnt <= '0;
            end else if (waiting && (MAX_WAIT != 0)) begin
                if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt >= WAIT_LIMIT - 1'b1) mem_timeout <= 1'b1;
            end
        end
    end

`ifdef LEGV8_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retired      <= '0;
            stall_cycles <= '0;
        end else begin
            if (state != ST_FETCH && state != ST_DECODE && state_nxt == ST_FETCH)
                retired <= retired + 32'd1;
            if (waiting)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

    // Outputs are forced low while reset is held so an aborted access issues nothing.
    assign ir_write   = !reset && ctl.fetch && mem_ready;
    assign pc_write   = !reset && ((ctl.fetch && mem_ready) || ctl.pcw_uncond ||
                                   (ctl.pcw_zero && zero) || (ctl.pcw_nzero && !zero));
    assign pc_src     = !reset && ctl.pc_src;
    assign reg2loc    = !reset && (ctl.reg2loc ||
                        (in_decode && (dec_cls == CL_ST || dec_cls == CL_CBZ || dec_cls == CL_CBNZ)));
    assign alu_src    = !reset && ctl.alu_src;
    assign mem_to_reg = !reset && ctl.mem_to_reg;
    assign reg_write  = !reset && ctl.reg_write;
    assign mem_read   = !reset && ctl.mem_read;
    assign mem_write  = !reset && ctl.mem_write;
    assign alu_op     = reset ? '0 : ALUOP_W'(ctl.alu_op);
    assign illegal    = !reset && in_decode && (dec_cls == CL_ILL);
    assign state_o    = state;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed-vector bench for legv8_multicycle_control with hand-computed control words.
module tb_legv8_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic        ir_write, pc_write, pc_src, reg2loc, alu_src, mem_to_reg;
    logic        reg_write, mem_read, mem_write, illegal, mem_timeout;
    logic [1:0]  alu_op;
    logic [2:0]  state_o;
`ifdef LEGV8_CTRL_PERF_EN
    logic [31:0] retired, stall_cycles;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // {ir, pcw, pcs, r2l, asrc, m2r, rw, mr, mw, aop[1:0], ill}
    logic [11:0] outv;
    assign outv = {ir_write, pc_write, pc_src, reg2loc, alu_src, mem_to_reg,
                   reg_write, mem_read, mem_write, alu_op, illegal};

    localparam logic [11:0] V_F_RDY  = 12'b110010010000;
    localparam logic [11:0] V_F_WAIT = 12'b000010010000;
    localparam logic [11:0] V_NONE   = 12'b000000000000;
    localparam logic [11:0] V_D_R2L  = 12'b000100000000;
    localparam logic [11:0] V_D_ILL  = 12'b000000000001;
    localparam logic [11:0] V_E_R    = 12'b000000000100;
    localparam logic [11:0] V_E_I    = 12'b000010000110;
    localparam logic [11:0] V_E_MEM  = 12'b000010000000;
    localparam logic [11:0] V_E_CB_T = 12'b011100000010;
    localparam logic [11:0] V_E_CB_N = 12'b001100000010;
    localparam logic [11:0] V_E_B    = 12'b011000000000;
    localparam logic [11:0] V_M_LD   = 12'b000000010000;
    localparam logic [11:0] V_M_ST   = 12'b000000001000;
    localparam logic [11:0] V_WB_R   = 12'b000000100000;
    localparam logic [11:0] V_WB_LD  = 12'b000001100000;

    legv8_multicycle_control #(.OPC_W(11), .ALUOP_W(2), .MAX_WAIT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .reg2loc     (reg2loc),
        .alu_src     (alu_src),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .alu_op      (alu_op),
        .illegal     (illegal),
        .mem_timeout (mem_timeout),
        .state_o     (state_o)
`ifdef LEGV8_CTRL_PERF_EN
        ,
        .retired     (retired),
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check state and control word mid-cycle, then clock.
    task automatic cyc(input string tag, input logic [2:0] es, input logic [11:0] eo,
                       input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        #1;
        check({tag, " state"}, 32'(state_o), 32'(es));
        check({tag, " ctl"},   32'(outv),    32'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        @(posedge clk);
        #1;
        check("rst state", 32'(state_o), 32'd0);
        check("rst ctl", 32'(outv), 32'd0);
        check("rst timeout", 32'(mem_timeout), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        opcode    = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        do_reset();

        // ADD: 4 cycles, reg_write only in WB
        opcode = 11'b10001011000;
        cyc("add_f", 3'd0, V_F_RDY, 1'b1, 1'b0);
        cyc("add_d", 3'd1, V_NONE,  1'b1, 1'b0);
        cyc("add_e", 3'd2, V_E_R,   1'b1, 1'b0);
        cyc("add_w", 3'd4, V_WB_R,  1'b1, 1'b0);

        // LDUR with two MEM wait cycles: 7 cycles total
        opcode = 11'b11111000010;
        cyc("ld_f",  3'd0, V_F_RDY, 1'b1, 1'b0);
        cyc("ld_d",  3'd1, V_NONE,  1'b1, 1'b0);
        cyc("ld_e",  3'd2, V_E_MEM, 1'b1, 1'b0);
        cyc("ld_m1", 3'd3, V_M_LD,  1'b0, 1'b0);
        cyc("ld_m2", 3'd3, V_M_LD,  1'b0, 1'b0);
        cyc("ld_m3", 3'd3, V_M_LD,  1'b1, 1'b0);
        cyc("ld_w",  3'd4, V_WB_LD, 1'b1, 1'b0);

        // STUR zero-wait: 4 cycles
        opcode = 11'b11111000000;
        cyc("st_f", 3'd0, V_F_RDY, 1'b1, 1'b0);
        cyc("st_d", 3'd1, V_D_R2L, 1'b1, 1'b0);
        cyc("st_e", 3'd2, V_E_MEM, 1'b1, 1'b0);
        cyc("st_m", 3'd3, V_M_ST,  1'b1, 1'b0);

        // CBZ taken / not taken
        opcode = 11'b10110100101;
        cyc("cbz1_f", 3'd0, V_F_RDY,  1'b1, 1'b1);
        cyc("cbz1_d", 3'd1, V_D_R2L,  1'b1, 1'b1);
        cyc("cbz1_e", 3'd2, V_E_CB_T, 1'b1, 1'b1);
        cyc("cbz0_f", 3'd0, V_F_RDY,  1'b1, 1'b0);
        cyc("cbz0_d", 3'd1, V_D_R2L,  1'b1, 1'b0);
        cyc("cbz0_e", 3'd2, V_E_CB_N, 1'b1, 1'b0);

        // CBNZ: branch sense inverted
        opcode = 11'b10110101011;
        cyc("cbnz1_f", 3'd0, V_F_RDY,  1'b1, 1'b1);
        cyc("cbnz1_d", 3'd1, V_D_R2L,  1'b1, 1'b1);
        cyc("cbnz1_e", 3'd2, V_E_CB_N, 1'b1, 1'b1);
        cyc("cbnz0_f", 3'd0, V_F_RDY,  1'b1, 1'b0);
        cyc("cbnz0_d", 3'd1, V_D_R2L,  1'b1, 1'b0);
        cyc("cbnz0_e", 3'd2, V_E_CB_T, 1'b1, 1'b0);

        // B
        opcode = 11'b00010111111;
        cyc("b_f", 3'd0, V_F_RDY, 1'b1, 1'b0);
        cyc("b_d", 3'd1, V_NONE,  1'b1, 1'b0);
        cyc("b_e", 3'd2, V_E_B,   1'b1, 1'b0);

        // SUBI
        opcode = 11'b11010001001;
        cyc("subi_f", 3'd0, V_F_RDY, 1'b1, 1'b0);
        cyc("subi_d", 3'd1, V_NONE,  1'b1, 1'b0);
        cyc("subi_e", 3'd2, V_E_I,   1'b1, 1'b0);
        cyc("subi_w", 3'd4, V_WB_R,  1'b1, 1'b0);

        // Illegal opcode: one-cycle pulse in DECODE, back to FETCH
        opcode = 11'b00000000000;
        cyc("ill_f",  3'd0, V_F_RDY, 1'b1, 1'b0);
        cyc("ill_d",  3'd1, V_D_ILL, 1'b1, 1'b0);
        check("no timeout", 32'(mem_timeout), 32'd0);

        // Reset during STUR MEM aborts the store
        opcode = 11'b11111000000;
        cyc("stx_f", 3'd0, V_F_RDY, 1'b1, 1'b0);
        cyc("stx_d", 3'd1, V_D_R2L, 1'b1, 1'b0);
        cyc("stx_e", 3'd2, V_E_MEM, 1'b1, 1'b0);
        cyc("stx_m", 3'd3, V_M_ST,  1'b0, 1'b0);
        reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("rst_mid ctl", 32'(outv), 32'd0);
        @(posedge clk);
        #1;
        check("rst_mid state", 32'(state_o), 32'd0);
        check("rst_mid ctl2",  32'(outv),    32'd0);
        reset = 1'b0;
        cyc("rst_mid f", 3'd0, V_F_WAIT, 1'b0, 1'b0);

        // Memory timeout: sets on the 15th consecutive wait cycle and stays set
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            mem_ready = 1'b0;
            @(posedge clk);
            #1;
            if (i == 14) check("timeout@14", 32'(mem_timeout), 32'd0);
            if (i == 15) check("timeout@15", 32'(mem_timeout), 32'd1);
        end
        check("timeout hold state", 32'(state_o), 32'd0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("timeout sticky", 32'(mem_timeout), 32'd1);
        check("timeout resume", 32'(state_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/legv8_multicycle_control.md
Name: legv8_multicycle_control

Overview:
Multi-cycle control FSM for the LEGv8 core, replacing the single-cycle combinational decoder.
- Sequences fetch, decode, execute, memory and write-back over several cycles.
- Stalls on a memory-ready handshake.
- Decodes a wider instruction set: LDUR, STUR, CBZ, CBNZ, B, R-type, ADDI/SUBI.
- Drives datapath mux selects and write enables each cycle; sits between the instruction register and the shared datapath.

Parameters:
OPC_W, 11, opcode field width taken from instruction[31:21].
ALUOP_W, 2, width of alu_op output.
MAX_WAIT, 15, memory wait-cycle limit before mem_timeout asserts; 0 disables the limit.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
opcode  in  OPC_W  instruction[31:21] from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
ir_write  out  1  load instruction register
pc_write  out  1  unconditional PC update (PC+4 or branch target)
pc_src  out  1  0 = PC+4, 1 = branch target
reg2loc  out  1  read register 2 select: 0 = Rm, 1 = Rt
alu_src  out  1  0 = register, 1 = immediate
mem_to_reg  out  1  write-back from memory
reg_write  out  1  register file write enable
mem_read  out  1  memory read request
mem_write  out  1  memory write request
alu_op  out  ALUOP_W  00 = add, 01 = pass/compare-zero, 10 = R-type funct, 11 = I-type
illegal  out  1  one-cycle pulse on unrecognised opcode
mem_timeout  out  1  sticky flag; cleared only by reset
state_o  out  3  current state, for debug

Behaviour:
- Reset, synchronous and active-high on clk:
  - state = FETCH; all outputs 0; mem_timeout = 0; wait counter = 0.
  - Reset mid-access aborts the access; no pc_write or reg_write is issued.
- Opcode latch: decoded class is latched in DECODE and held stable until the next FETCH.
- Outputs are Moore-decoded from the state and latched class, except:
  - ir_write and pc_write in FETCH, which are gated by mem_ready.
  - pc_write in EXEC for conditional branches, which is gated by zero.
- FETCH:
  - mem_read = 1, alu_src = 1, alu_op = 00 (PC+4).
  - mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0; go to DECODE.
  - mem_ready = 0: remain in FETCH.
- DECODE:
  - Classify the opcode.
  - reg2loc = 1 for STUR/CBZ/CBNZ, otherwise 0.
  - Illegal opcode: illegal = 1 for this cycle, then FETCH.
  - Legal opcode: go to EXEC.
- EXEC:
  - R-type: alu_op = 10 -> WB.
  - ADDI/SUBI: alu_src = 1, alu_op = 11 -> WB.
  - LDUR/STUR: alu_src = 1, alu_op = 00 -> MEM.
  - CBZ: alu_op = 01, reg2loc = 1; pc_src = 1 and pc_write = zero -> FETCH.
  - CBNZ: same as CBZ but pc_write = !zero -> FETCH.
  - B: pc_src = 1, pc_write = 1 -> FETCH.
- MEM:
  - LDUR: mem_read = 1. STUR: mem_write = 1.
  - Requests are held until mem_ready.
  - On mem_ready: LDUR -> WB; STUR -> FETCH.
- WB:
  - reg_write = 1; mem_to_reg = 1 for LDUR only -> FETCH.
- Latency with zero-wait memory:
  - R/I-type: 4 cycles. LDUR: 5. STUR: 4. CBZ/CBNZ/B: 3.
  - Each wait cycle adds 1.
- Memory wait counter:
  - Counts consecutive cycles with mem_ready = 0 in FETCH or MEM.
  - Clears to 0 on mem_ready = 1.
  - Saturates at MAX_WAIT and sets mem_timeout, which stays set.
  - The FSM keeps waiting after a timeout; there is no forced exit.
- Never assert mem_read and mem_write in the same cycle.
- Never assert reg_write outside WB.
- Opcode decode:
  - Exact match for LDUR 11111000010 and STUR 11111000000.
  - Don't-care low bits for CBZ 10110100xxx, CBNZ 10110101xxx, B 000101xxxxx.
  - R-type matches 1xx0101x000. ADDI/SUBI match 1x0100010xx.
  - If the patterns overlap, the first match in the order listed wins.

Optional Feature:
LEGV8_CTRL_PERF_EN:
- Defined: adds output ports retired[31:0] and stall_cycles[31:0].
  - retired increments on each transition into FETCH from EXEC, MEM or WB.
  - stall_cycles increments on each cycle with mem_ready = 0 in FETCH or MEM.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Package legv8_ctrl_pkg holds:
  - State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4.
  - Instruction-class enum: R, I, LD, ST, CBZ, CBNZ, B, ILL.
  - Opcode pattern constants and alu_op encodings.
- Sub-module legv8_opcode_classify: combinational, opcode in, class out; shared with the future pipelined core.

Test Plan:
- ADD opcode 10001011000, mem_ready held 1 -> states F, D, E, WB, F; reg_write high only in cycle 4; alu_op = 10 in EXEC.
- LDUR with mem_ready low for 2 cycles in MEM -> MEM held 3 cycles with mem_read = 1; WB with mem_to_reg = 1; total 7 cycles.
- CBZ 10110100101 with zero = 1 -> pc_write = 1, pc_src = 1 in EXEC; with zero = 0 -> pc_write = 0; back to FETCH after 3 cycles. Repeat with CBNZ: results inverted.
- Opcode 00000000000 -> illegal pulses 1 cycle in DECODE; no reg_write or mem_write; next state FETCH.
- mem_ready held 0 in FETCH for 16 cycles (MAX_WAIT = 15) -> mem_timeout rises at the 15th wait cycle and stays 1 after mem_ready returns.
- reset asserted during MEM of STUR -> next cycle state_o = 0, mem_write = 0, all outputs 0.
